// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request bus between the fetch sequencer (master) and imem (slave).
interface fetch_sequencer_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, one imem request in flight, valid/stall to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects are rejected and flagged on misalign_err.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_sequencer_if.master    imem,
  input  logic                 PCSrc_F,
  input  logic [63:0]          PCBranch_F,
  input  logic                 stall_D,
  output logic                 instr_valid_F,
  output logic [31:0]          instr_F,
  output logic [63:0]          pc_F,
  output logic [CNT_W-1:0]     fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                 misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               discard_q, discard_d;
  logic [31:0]        instr_q, instr_d;
  logic [63:0]        pc_f_q, pc_f_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               redir_c;
  logic [63:0]        target_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic               merr_q, merr_d;
  logic               misaligned_c;

  // A misaligned target is refused outright; only the sticky flag records it.
  assign misaligned_c = PCSrc_F && (PCBranch_F[1:0] != 2'b00);
  assign redir_c      = PCSrc_F && !misaligned_c;
  assign target_c     = PCBranch_F;
  assign misalign_err = merr_q;
`else
  assign redir_c      = PCSrc_F;
  assign target_c     = PCBranch_F & ~64'h3;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect always abandons whatever the current fetch was doing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (imem.imem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = (redir_c || discard_q) ? S_REQ : S_OUT;
        end
      end
      S_OUT:  if (redir_c || !stall_D) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    pc_f_d    = pc_f_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_BOOT: ;
      S_REQ: begin
        if (redir_c) begin
          pc_d = target_c;
          // Old address was accepted this cycle; its response must be thrown away.
          if (imem.imem_gnt) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redir_c) pc_d = target_c;
        if (imem.imem_rvalid) begin
          discard_d = 1'b0;
          if (!redir_c && !discard_q) begin
            instr_d = imem.imem_rdata;
            pc_f_d  = pc_q;
            pc_d    = pc_q + 64'(PC_INC);
          end
        end else if (redir_c) begin
          discard_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redir_c) begin
          pc_d = target_c;
        end else if (!stall_D) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_OUT);
`ifdef FETCH_MISALIGN_TRAP_EN
    merr_d  = merr_q | (misaligned_c && (state_q != S_BOOT));
`endif
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      instr_q   <= 32'h0;
      pc_f_q    <= 64'h0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      merr_q    <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pc_f_q    <= pc_f_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      merr_q    <= merr_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_valid_F  = valid_q;
  assign instr_F        = instr_q;
  assign pc_F           = pc_f_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: echo memory with programmable latency, transaction-level PC model, directed scenarios.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic        stall_D;
  logic        instr_valid_F;
  logic [31:0] instr_F;
  logic [63:0] pc_F;
  logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(64'h0), .PC_INC(4), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus.master),
    .PCSrc_F       (PCSrc_F),
    .PCBranch_F    (PCBranch_F),
    .stall_D       (stall_D),
    .instr_valid_F (instr_valid_F),
    .instr_F       (instr_F),
    .pc_F          (pc_F),
    .fetch_count   (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Echo memory: grants immediately, answers rlat cycles later with the address as data.
  int          rlat = 1;
  logic        m_pending = 1'b0;
  logic [63:0] m_paddr = 64'h0;
  int          m_cnt = 0;

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    if (!reset) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = m_paddr[31:0];
        m_pending       = 1'b0;
      end
    end else if (bus.imem_req) begin
      bus.imem_gnt = 1'b1;
      m_pending    = 1'b1;
      m_paddr      = bus.imem_addr;
      m_cnt        = rlat;
    end
  end

  // Model: the next instruction delivered must come from the next sequential PC or the latest redirect target.
  logic [63:0] m_exp;
  logic [63:0] m_pc;
  logic        m_hold;
  logic [31:0] m_fc;
  logic        m_merr;
  logic        redir_eff;
  logic [63:0] redir_tgt;

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    redir_eff = PCSrc_F && (PCBranch_F[1:0] == 2'b00);
    redir_tgt = PCBranch_F;
`else
    redir_eff = PCSrc_F;
    redir_tgt = PCBranch_F & ~64'h3;
`endif
  end

  always @(negedge clk) begin
    if (!reset) begin
      m_exp  = 64'h0;
      m_pc   = 64'h0;
      m_hold = 1'b0;
      m_fc   = 32'h0;
      m_merr = 1'b0;
    end else begin
      chk("fetch_count", 64'(fetch_count), 64'(m_fc));
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign_err", 64'(misalign_err), 64'(m_merr));
`endif
      chk("req_and_valid_exclusive", 64'(bus.imem_req & instr_valid_F), 64'h0);
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, m_exp);
      if (instr_valid_F) begin
        if (!m_hold) begin
          m_pc  = m_exp;
          m_exp = m_exp + 64'd4;
        end
        chk("pc_F", pc_F, m_pc);
        chk("instr_F", 64'(instr_F), 64'(m_pc[31:0]));
        m_hold = stall_D && !redir_eff;
        if (!stall_D && !redir_eff) m_fc = m_fc + 32'd1;
      end else begin
        m_hold = 1'b0;
      end
      if (redir_eff) begin
        m_exp  = redir_tgt;
        m_hold = 1'b0;
      end
      if (PCSrc_F && !redir_eff) m_merr = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_valid_pc(input logic [63:0] p);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (instr_valid_F && pc_F == p) found = 1;
    end
    chk("wait_valid_pc_timeout", 64'(found), 64'h1);
  endtask

  task automatic wait_next_valid();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (instr_valid_F) found = 1;
    end
    chk("wait_valid_timeout", 64'(found), 64'h1);
  endtask

  task automatic wait_next_req();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (bus.imem_req) found = 1;
    end
    chk("wait_req_timeout", 64'(found), 64'h1);
  endtask

  task automatic wait_gnt();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (bus.imem_gnt) found = 1;
    end
    chk("wait_gnt_timeout", 64'(found), 64'h1);
  endtask

  initial begin
    reset      = 1'b0;
    PCSrc_F    = 1'b0;
    PCBranch_F = 64'h0;
    stall_D    = 1'b0;
    #1;
    chk("reset_req", 64'(bus.imem_req), 64'h0);
    chk("reset_valid", 64'(instr_valid_F), 64'h0);
    chk("reset_instr", 64'(instr_F), 64'h0);
    chk("reset_pc_F", pc_F, 64'h0);
    chk("reset_count", 64'(fetch_count), 64'h0);

    // Back-to-back fetch: valid every third cycle, PCs 0,4,8,12
    rlat = 1;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("seq_valid_cadence", 64'(instr_valid_F), 64'((i % 3) == 0));
      if ((i % 3) == 0) chk("seq_pc_F", pc_F, 64'(4 * (i / 3 - 1)));
    end
    step();
    chk("seq_count_after_4", 64'(fetch_count), 64'd4);

    // Stall while holding pc_F=8
    do_reset();
    wait_valid_pc(64'd8);
    stall_D = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 64'(instr_valid_F), 64'h1);
      chk("stall_pc_F", pc_F, 64'd8);
      chk("stall_instr", 64'(instr_F), 64'd8);
      chk("stall_no_req", 64'(bus.imem_req), 64'h0);
      chk("stall_count", 64'(fetch_count), 64'd2);
    end
    stall_D = 1'b0;
    wait_next_valid();
    chk("stall_resume_pc", pc_F, 64'd12);
    chk("stall_resume_count", 64'(fetch_count), 64'd3);

    // Redirect during a slow WAIT: stale response must be squashed
    rlat = 4;
    do_reset();
    wait_gnt();
    step();
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'd456789 & ~64'd3;
    step();
    PCSrc_F    = 1'b0;
    wait_next_req();
    chk("wait_redir_addr", bus.imem_addr, 64'd456788);
    wait_next_valid();
    chk("wait_redir_pc", pc_F, 64'd456788);
    chk("wait_redir_instr", 64'(instr_F), 64'd456788);

    // Redirect coincident with the grant of address 16
    rlat = 1;
    do_reset();
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        step();
        if (bus.imem_req && bus.imem_gnt && bus.imem_addr == 64'd16) hit = 1;
      end
      chk("gnt16_seen", 64'(hit), 64'h1);
    end
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'd100;
    step();
    PCSrc_F    = 1'b0;
    wait_next_req();
    chk("gnt_redir_addr", bus.imem_addr, 64'd100);
    wait_next_valid();
    chk("gnt_redir_pc", pc_F, 64'd100);
    chk("gnt_redir_instr", 64'(instr_F), 64'd100);

    // Redirect in OUT flushes without counting
    do_reset();
    wait_valid_pc(64'd4);
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'd200;
    step();
    PCSrc_F    = 1'b0;
    chk("flush_valid", 64'(instr_valid_F), 64'h0);
    chk("flush_count", 64'(fetch_count), 64'd1);
    wait_next_valid();
    chk("flush_next_pc", pc_F, 64'd200);

    // Asynchronous reset in WAIT
    rlat = 4;
    do_reset();
    wait_valid_pc(64'd8);
    wait_gnt();
    step();
    reset = 1'b0;
    #1;
    chk("areset_req", 64'(bus.imem_req), 64'h0);
    chk("areset_valid", 64'(instr_valid_F), 64'h0);
    chk("areset_instr", 64'(instr_F), 64'h0);
    chk("areset_pc_F", pc_F, 64'h0);
    chk("areset_count", 64'(fetch_count), 64'h0);
    step();
    step();
    reset = 1'b1;
    wait_next_valid();
    chk("areset_restart_pc", pc_F, 64'h0);

    // Misaligned target 0x102 redirected in OUT
    rlat = 1;
    do_reset();
    wait_valid_pc(64'd4);
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h102;
    step();
    PCSrc_F    = 1'b0;
    wait_next_valid();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_flag", 64'(misalign_err), 64'h1);
    chk("misalign_seq_pc", pc_F, 64'd8);
    chk("misalign_count", 64'(fetch_count), 64'd2);
`else
    chk("align_mask_pc", pc_F, 64'h100);
    chk("align_mask_count", 64'(fetch_count), 64'd1);
`endif
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the IF stage of the pipelined LEGv8 core. Owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake, which tolerates variable memory latency. Presents fetched instructions to decode through a valid/stall handshake. Applies branch redirects (PCSrc_F / PCBranch_F) from the execute/memory stages, including squashing a response that is already in flight.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
PC_INC, 4, sequential PC increment in bytes
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  request to instruction memory
imem_addr  output  64  request address; always equals the internal PC
imem_gnt  input  1  memory accepts the request this cycle (sampled only while imem_req=1)
imem_rvalid  input  1  read data valid; at most one per granted request
imem_rdata  input  32  instruction word
PCSrc_F  input  1  branch taken; redirect to PCBranch_F
PCBranch_F  input  64  branch target
stall_D  input  1  decode cannot accept this cycle
instr_valid_F  output  1  instr_F / pc_F hold a valid instruction
instr_F  output  32  fetched instruction
pc_F  output  64  address of instr_F
fetch_count  output  CNT_W  number of instructions consumed by decode

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, PC=RESET_PC, discard=0.
  - imem_req=0, instr_valid_F=0, instr_F=0, pc_F=0, fetch_count=0.
- States: BOOT, REQ, WAIT, OUT. All transitions occur on the rising edge of clk.
- BOOT: imem_req=0. Moves to REQ unconditionally on the first edge after reset is released.
- REQ:
  - imem_req=1, imem_addr=PC.
  - imem_gnt=1 -> WAIT.
  - Otherwise remain in REQ; the request stays asserted.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 and discard=0 -> instr_F<=imem_rdata, pc_F<=PC, PC<=PC+PC_INC, go to OUT.
  - imem_rvalid=1 and discard=1 -> drop the data, clear discard, go to REQ (the PC already holds the target).
- OUT:
  - instr_valid_F=1; instr_F and pc_F are held stable.
  - stall_D=0 -> consumed: fetch_count increments, go to REQ.
  - stall_D=1 -> remain in OUT.
- instr_valid_F is 1 only in OUT and is registered.
- Minimum throughput: one instruction per 3 cycles (REQ, WAIT, OUT) with single-cycle gnt and rvalid.
- Redirect (PCSrc_F=1) has highest priority. PC<=PCBranch_F in every state except BOOT, where it is ignored. Per state:
  - REQ, gnt=0: stay in REQ; imem_addr shows the target from the next cycle.
  - REQ, gnt=1 in the same cycle: the old address was accepted; go to WAIT with discard=1.
  - WAIT, rvalid=0: discard<=1, stay in WAIT.
  - WAIT, rvalid=1: drop the data, go to REQ.
  - OUT: flush. instr_valid_F<=0, no count increment even if stall_D=0, go to REQ.
  - Repeated redirect while discard=1: PC updates to the newest target; discard stays 1.
- Arithmetic:
  - PC+PC_INC wraps modulo 2^64.
  - fetch_count wraps modulo 2^CNT_W.
- Unsolicited imem_rvalid outside WAIT is ignored.
- Reset asserted mid-transaction returns everything to reset values immediately. The memory must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with PCBranch_F[1:0]!=0 is not applied: the PC is unchanged and no flush or discard occurs.
  - misalign_err is set and stays set (sticky) until reset.
- Not defined:
  - No misalign_err port.
  - The PC loads {PCBranch_F[63:2], 2'b00}.

Test Plan:
- Reset with RESET_PC=0, memory with 1-cycle gnt/rvalid returning the address as data, stall_D=0 -> pc_F sequence 0,4,8,12; instr_valid_F high every 3rd cycle; fetch_count=4 after the 4th consumption.
- stall_D=1 for 5 cycles while in OUT with pc_F=8 -> instr_F/pc_F stable; no new imem_req; fetch_count unchanged; resumes at 12 after stall_D drops.
- Memory with 4-cycle rvalid latency; PCSrc_F=1, PCBranch_F=64'd456789&~3 pulsed in WAIT -> stale response discarded; next imem_addr=456788; next pc_F=456788.
- PCSrc_F=1 in the same cycle as imem_gnt for address 16, target 100 -> response for 16 never appears on instr_F; next request at 100.
- Redirect in OUT with stall_D=0 -> instr_valid_F=0 next cycle; fetch_count not incremented.
- Reset pulsed low in WAIT -> all outputs 0 immediately; restarts at RESET_PC. With FETCH_MISALIGN_TRAP_EN, target 0x102 -> misalign_err=1 and the PC continues sequentially.
